store_narrow_buffer: RTL and testbench

Store-path counterpart of the immediate/load extender: narrows 32-bit register store data to byte, halfword or word lanes with byte enables, then queues the result in a small write buffer. The buffer drains to data memory over a valid/ready handshake. It sits between the MEM stage and the data-memory port. It also exposes a word-address hit check so hazard logic can stall a load that targets a pending store.

---
 rtl/store_narrow_buffer_if.sv | 27 ++
 rtl/store_narrow_buffer.sv | 67 ++++++
 tb/tb_store_narrow_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/store_narrow_buffer_if.sv
// store_narrow_buffer_if: store request, memory drain and load-hit signals of the store narrowing buffer
interface store_narrow_buffer_if #(parameter int CNT_W = 3);
  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [1:0]       st_size;
  logic             st_misalign;
  logic             mem_valid;
  logic             mem_ready;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic [31:0]      ld_addr;
  logic             ld_hit;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ready, ld_addr,
    input  st_ready, st_misalign, mem_valid, mem_addr, mem_wdata, mem_be, ld_hit, count, empty, full
  );
  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ready, ld_addr,
    output st_ready, st_misalign, mem_valid, mem_addr, mem_wdata, mem_be, ld_hit, count, empty, full
  );
endinterface

// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows store data to byte/half/word lanes and queues it in an in-order write buffer
module store_narrow_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic               clk,
  input logic               rst,
  store_narrow_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CNT_W-1:0] cnt;
  logic             mis_q;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic             legal, acc, enq, deq;
  logic [DEPTH-1:0] hit;
  logic [PW-1:0]    off [DEPTH];
  always_comb begin
    wdata = bus.st_size == 2'b00 ? {4{bus.st_data[7:0]}} :
            bus.st_size == 2'b01 ? {2{bus.st_data[15:0]}} : bus.st_data;
    be    = bus.st_size == 2'b00 ? 4'b0001 << bus.st_addr[1:0] :
            bus.st_size == 2'b01 ? (bus.st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    legal = bus.st_size == 2'b00 ||
            (bus.st_size == 2'b01 && !bus.st_addr[0]) ||
            (bus.st_size == 2'b10 && bus.st_addr[1:0] == 2'b00);
  end
  assign acc = bus.st_valid && bus.st_ready;
  assign enq = acc && legal;
  assign deq = bus.mem_valid && bus.mem_ready;
  assign bus.count       = cnt;
  assign bus.empty       = cnt == '0;
  assign bus.full        = cnt == CNT_W'(DEPTH);
  assign bus.st_ready    = !bus.full;
  assign bus.st_misalign = mis_q;
  assign bus.mem_valid   = !bus.empty;
  assign bus.mem_addr    = addr_q[head];
  assign bus.mem_wdata   = data_q[head];
  assign bus.mem_be      = be_q[head];
  // A slot is live only if its distance from head is below count, so stale slots never hit
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign off[i] = PW'(i) - head;
    assign hit[i] = CNT_W'(off[i]) < cnt && addr_q[i][31:2] == bus.ld_addr[31:2];
  end
  assign bus.ld_hit = |hit;
  always_ff @(posedge clk)
    if (enq && !rst) begin
      addr_q[tail] <= {bus.st_addr[31:2], 2'b00};
      data_q[tail] <= wdata;
      be_q[tail]   <= be;
    end
  always_ff @(posedge clk)
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      mis_q <= 1'b0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      cnt   <= cnt + CNT_W'(enq) - CNT_W'(deq);
      mis_q <= acc && !legal;
    end
endmodule

// File: tb/tb_store_narrow_buffer.sv
// tb_store_narrow_buffer: directed and randomized checks of store_narrow_buffer against a queue model
module tb_store_narrow_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total = 0;
  ent_t q[$];
  logic mis_exp = 1'b0;
  store_narrow_buffer_if #(.CNT_W(CNT_W)) b();
  store_narrow_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  function automatic bit is_legal(logic [31:0] a, logic [1:0] s);
    return s == 2'd0 || (s == 2'd1 && a % 2 == 0) || (s == 2'd2 && a % 4 == 0);
  endfunction
  function automatic ent_t narrow(logic [31:0] a, logic [31:0] d, logic [1:0] s);
    ent_t e;
    e.addr = a & ~32'h3;
    if (s == 2'd0) begin
      e.wdata = {24'h0, d[7:0]} * 32'h01010101;
      e.be    = 4'(1 << (a % 4));
    end else if (s == 2'd1) begin
      e.wdata = {16'h0, d[15:0]} * 32'h00010001;
      e.be    = 4'(3 << (a % 4));
    end else begin
      e.wdata = d;
      e.be    = 4'hf;
    end
    return e;
  endfunction
  function automatic bit exp_hit(logic [31:0] la);
    foreach (q[i]) if (q[i].addr == (la & ~32'h3)) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(b.count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(b.empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(b.full), 32'(q.size() == DEPTH));
    chk({tag, ".st_ready"}, 32'(b.st_ready), 32'(q.size() < DEPTH));
    chk({tag, ".mem_valid"}, 32'(b.mem_valid), 32'(q.size() > 0));
    chk({tag, ".misalign"}, 32'(b.st_misalign), 32'(mis_exp));
    chk({tag, ".ld_hit"}, 32'(b.ld_hit), 32'(exp_hit(b.ld_addr)));
    if (q.size() > 0) begin
      chk({tag, ".mem_addr"}, b.mem_addr, q[0].addr);
      chk({tag, ".mem_wdata"}, b.mem_wdata, q[0].wdata);
      chk({tag, ".mem_be"}, 32'(b.mem_be), 32'(q[0].be));
    end
  endtask
  // Decide accept/dequeue from the pre-edge model state, then apply after the edge
  task automatic cyc();
    bit acc, deq, leg;
    ent_t e;
    acc = b.st_valid && q.size() < DEPTH;
    deq = b.mem_ready && q.size() > 0;
    leg = is_legal(b.st_addr, b.st_size);
    e   = narrow(b.st_addr, b.st_data, b.st_size);
    @(posedge clk);
    if (rst) begin
      q.delete();
      mis_exp = 1'b0;
    end else begin
      if (deq) void'(q.pop_front());
      if (acc && leg) q.push_back(e);
      mis_exp = acc && !leg;
    end
    #1;
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    b.st_valid = 1'b1;
    b.st_addr  = a;
    b.st_data  = d;
    b.st_size  = s;
  endtask
  initial begin
    b.st_valid = 1'b0; b.st_addr = '0; b.st_data = '0; b.st_size = '0;
    b.mem_ready = 1'b0; b.ld_addr = 32'hffff_fff0;
    cyc(); cyc();
    rst = 1'b0;
    check_all("reset");
    // byte at 0x1003 drains next cycle
    b.mem_ready = 1'b1;
    st(32'h1003, 32'h1234_56a5, 2'd0);
    cyc();
    b.st_valid = 1'b0;
    chk("byte.mem_valid", 32'(b.mem_valid), 32'd1);
    chk("byte.mem_addr", b.mem_addr, 32'h1000);
    chk("byte.mem_wdata", b.mem_wdata, 32'ha5a5a5a5);
    chk("byte.mem_be", 32'(b.mem_be), 32'h8);
    check_all("byte");
    cyc();
    chk("byte.empty_after", 32'(b.empty), 32'd1);
    // half then word, held, then drained in order
    b.mem_ready = 1'b0;
    st(32'h2002, 32'hffff_1234, 2'd1); cyc();
    st(32'h2004, 32'hdead_beef, 2'd2); cyc();
    b.st_valid = 1'b0;
    chk("hw.count", 32'(b.count), 32'd2);
    chk("hw.head_wdata", b.mem_wdata, 32'h12341234);
    chk("hw.head_be", 32'(b.mem_be), 32'hc);
    check_all("hw");
    b.mem_ready = 1'b1;
    cyc();
    chk("hw.second_addr", b.mem_addr, 32'h2004);
    chk("hw.second_be", 32'(b.mem_be), 32'hf);
    check_all("hw.drain");
    cyc();
    check_all("hw.empty");
    // overfill by one with memory stalled
    b.mem_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      st(32'h6000 + 32'(4 * i), 32'h100 + 32'(i), 2'd2);
      cyc();
      check_all("fill");
    end
    chk("fill.full", 32'(b.full), 32'd1);
    chk("fill.st_ready", 32'(b.st_ready), 32'd0);
    b.mem_ready = 1'b1; cyc(); check_all("fill.deq");
    b.mem_ready = 1'b0; cyc(); check_all("fill.refill");
    b.st_valid = 1'b0;
    chk("fill.count", 32'(b.count), 32'(DEPTH));
    chk("fill.tail_kept", 32'(q[DEPTH-1].wdata), 32'h100 + 32'(DEPTH));
    b.mem_ready = 1'b1;
    repeat (DEPTH) begin cyc(); check_all("fill.drain"); end
    // illegal requests are dropped with a one-cycle pulse
    b.mem_ready = 1'b0;
    st(32'h3002, 32'h1, 2'd2); cyc(); b.st_valid = 1'b0;
    chk("mis.word", 32'(b.st_misalign), 32'd1); check_all("mis.word");
    cyc(); chk("mis.word_clear", 32'(b.st_misalign), 32'd0);
    st(32'h3001, 32'h2, 2'd1); cyc(); b.st_valid = 1'b0;
    chk("mis.half", 32'(b.st_misalign), 32'd1); check_all("mis.half");
    st(32'h3000, 32'h3, 2'd3); cyc(); b.st_valid = 1'b0;
    chk("mis.rsv", 32'(b.st_misalign), 32'd1);
    chk("mis.count", 32'(b.count), 32'd0);
    chk("mis.mem_valid", 32'(b.mem_valid), 32'd0);
    cyc(); check_all("mis.idle");
    // load hit detection
    st(32'h4008, 32'h77, 2'd2); cyc(); b.st_valid = 1'b0;
    b.ld_addr = 32'h400b; #1;
    chk("hit.same_word", 32'(b.ld_hit), 32'd1);
    b.ld_addr = 32'h400c; #1;
    chk("hit.next_word", 32'(b.ld_hit), 32'd0);
    b.mem_ready = 1'b1; cyc();
    b.ld_addr = 32'h4008; #1;
    chk("hit.drained", 32'(b.ld_hit), 32'd0);
    check_all("hit");
    // reset flushes pending entries and wins over accept/dequeue
    b.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin st(32'h4000 + 32'(4 * i), 32'(i), 2'd2); cyc(); end
    chk("rst.pre_count", 32'(b.count), 32'd3);
    rst = 1'b1; b.mem_ready = 1'b1; st(32'h4100, 32'h9, 2'd2);
    cyc();
    rst = 1'b0; b.st_valid = 1'b0;
    chk("rst.count", 32'(b.count), 32'd0);
    chk("rst.mem_valid", 32'(b.mem_valid), 32'd0);
    check_all("rst");
    // randomized traffic wraps the pointers many times
    for (int n = 0; n < 400; n++) begin
      b.st_valid  = 1'($urandom_range(0, 3) != 0);
      b.st_addr   = 32'h5000 + 32'($urandom_range(0, 31));
      b.st_data   = $urandom;
      b.st_size   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      b.mem_ready = 1'($urandom_range(0, 2) != 0);
      b.ld_addr   = 32'h5000 + 32'($urandom_range(0, 31));
      #1;
      check_all("rand.pre");
      cyc();
      check_all("rand");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
